wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage of the pipelined core. Sits directly downstream of the memory stage and consumes its valid/instr/data output.
- Holds one pipeline entry and commits it to the integer register file, which is instantiated inside this block.
- Provides two bypassed read ports for the decode stage and exposes the pending destination register for hazard detection.

Parameters:
- BITSIZE, 32, data width of registers and data path.
- NREGS, 32, number of architectural registers (x0 hardwired to zero).

Ports:
- clk  in  1  core clock
- rst_i  in  1  synchronous reset, active-high
- halt_i  in  1  freeze all state (entry, regfile, counter)
- valid_i  in  1  memory stage has a valid entry
- ack_o  out  1  entry accepted this cycle
- instr_i  in  32  instruction word of the entry
- data_i  in  BITSIZE  result/load data/link address
- rs1_addr_i  in  5  read port 1 address
- rs1_data_o  out  BITSIZE  read port 1 data
- rs2_addr_i  in  5  read port 2 address
- rs2_data_o  out  BITSIZE  read port 2 data
- wb_valid_o  out  1  held entry will write a register this cycle
- wb_rd_o  out  5  destination of held entry
- instret_o  out  64  retired-instruction count (see Optional Feature)

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst_i; all state updates on posedge clk.
- Reset (rst_i=1 at an edge):
  - entry valid cleared, all registers set to 0, instret cleared.
  - Reset takes priority over halt_i.
  - During reset: ack_o=0, wb_valid_o=0, wb_rd_o=0, read data=0.
- ack_o = valid_i & !halt_i & !rst_i (combinational).
  - The entry always drains in one cycle, so the stage never back-pressures except on halt.
- Accept: on an edge with ack_o=1, latch {valid=1, instr_i, data_i}.
  - Without a new accept, valid clears at the next non-halted edge.
- Writeback decode on the held instr, opcode [6:0]:
  - we=1 for LOAD, OP-IMM, OP, LUI, AUIPC, JAL, JALR.
  - we=0 for STORE, BRANCH, SYSTEM, FENCE, unknown.
  - rd = instr[11:7]; rd==0 forces we=0.
- Commit: while the entry is valid and we=1, the register file is written with data at the next non-halted edge. Latency from accept to committed register = 1 cycle; visible in the array 2 edges after valid_i.
- Back-to-back: accept and commit happen at the same edge. The new entry overwrites the held entry after that entry's write.
- wb_valid_o = entry.valid & we; wb_rd_o = entry rd (0 when wb_valid_o=0).
- Read ports (combinational):
  - address 0 -> 0.
  - else if wb_valid_o and address==wb_rd_o -> held data (bypass).
  - else array content.
  - Both ports are independent; identical addresses are allowed.
- Halt: no writes, no counter change, and the entry is held. Outputs continue to reflect held state.
- Data is written as-is. Sign extension and sub-word handling are done upstream.

Optional Feature:
- Macro: WB_INSTRET_EN.
- Defined:
  - 64-bit counter incremented by 1 at each non-halted edge where the held entry is valid, for any opcode (stores and branches included).
  - Wraps modulo 2^64.
  - instret_o = counter.
- Undefined: no counter flops; instret_o tied to 0.

Decomposition:
- Shared package (with the existing instruction defines): opcode constants for LOAD/STORE/OP/OP-IMM/LUI/AUIPC/JAL/JALR/BRANCH, and a wb_entry_t packed struct {valid, instr, data}.
- Natural sub-module: register_file. It holds the NREGS x BITSIZE array, one write port and two raw read ports, with synchronous reset. Bypass and x0 handling stay in wb_stage.

Test Plan:
- Reset: hold rst_i 2 cycles with valid_i=1 -> ack_o=0, rs1_data_o=0 for all addresses, instret_o=0.
- ALU writeback: instr OP-IMM rd=5, data=0xDEADBEEF. Then rs1_addr_i=5 -> bypass 0xDEADBEEF while held; array holds 0xDEADBEEF after the next edge.
- x0 and store: LUI rd=0 data=0x1234, then STORE with data=0 -> wb_valid_o=0 both cycles, x0 reads 0. With WB_INSTRET_EN, instret_o=2.
- Back-to-back same rd: JAL rd=1 data=0x104, then LOAD rd=1 data=0x55 on consecutive cycles -> rs2 on x1 reads 0x104 then 0x55; final array value 0x55.
- Halt: hold entry rd=3 data=7, assert halt_i 3 cycles with valid_i=1 -> ack_o=0, x3 unchanged in array, wb_valid_o stays 1, instret constant. Commit occurs on the first edge after release.
- Reset mid-operation: assert rst_i while entry rd=4 is held -> no write to x4, all outputs 0 next cycle.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage.
// Opcode constants, held-entry bundle and writeback decode helper.
package wb_stage_pkg;

   localparam int DATA_W = 32;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic              valid;
      logic [31:0]       instr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   // Register write intent of an instruction; rd==x0 never writes.
   function automatic logic wb_writes(input logic [31:0] instr);
      logic w;
      w = 1'b0;
      case (instr[6:0])
         OPC_LOAD, OPC_OP_IMM, OPC_OP,
         OPC_LUI, OPC_AUIPC,
         OPC_JAL, OPC_JALR: w = 1'b1;
         default:           w = 1'b0;
      endcase
      return w && (instr[11:7] != 5'd0);
   endfunction

endpackage

// File: rtl/wb_stage_register_file.sv
// Integer register array: one write port, two raw read ports.
// Synchronous reset clears every entry; x0 handling lives upstream.
module wb_stage_register_file #(
   parameter int BITSIZE = 32,
   parameter int NREGS   = 32
) (
   input  logic               clk,
   input  logic               rst_i,
   input  logic               we,
   input  logic [4:0]         waddr,
   input  logic [BITSIZE-1:0] wdata,
   input  logic [4:0]         raddr1,
   output logic [BITSIZE-1:0] rdata1,
   input  logic [4:0]         raddr2,
   output logic [BITSIZE-1:0] rdata2
);

   logic [BITSIZE-1:0] regs [NREGS];

   // Clear on reset, otherwise write the committed value.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = regs[raddr1];
   assign rdata2 = regs[raddr2];

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: holds one entry, commits it to the regfile.
// Bypassed read ports; WB_INSTRET_EN adds a 64-bit retire counter.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int BITSIZE = 32,
   parameter int NREGS   = 32
) (
   input  logic               clk,
   input  logic               rst_i,
   input  logic               halt_i,
   input  logic               valid_i,
   output logic               ack_o,
   input  logic [31:0]        instr_i,
   input  logic [BITSIZE-1:0] data_i,
   input  logic [4:0]         rs1_addr_i,
   output logic [BITSIZE-1:0] rs1_data_o,
   input  logic [4:0]         rs2_addr_i,
   output logic [BITSIZE-1:0] rs2_data_o,
   output logic               wb_valid_o,
   output logic [4:0]         wb_rd_o,
   output logic [63:0]        instret_o
);

   wb_entry_t          entry_q;
   logic               we;
   logic               commit;
   logic [4:0]         rd;
   logic [BITSIZE-1:0] held;
   logic [BITSIZE-1:0] raw1;
   logic [BITSIZE-1:0] raw2;

   assign rd     = entry_q.instr[11:7];
   assign held   = BITSIZE'(entry_q.data);
   assign we     = entry_q.valid & wb_writes(entry_q.instr) & ~rst_i;
   assign commit = we & ~halt_i;

   assign ack_o      = valid_i & ~halt_i & ~rst_i;
   assign wb_valid_o = we;
   assign wb_rd_o    = we ? rd : 5'd0;

   // Latch the incoming entry; a halt freezes the held one.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         entry_q <= '0;
      end else if (!halt_i) begin
         entry_q.valid <= valid_i;
         entry_q.instr <= instr_i;
         entry_q.data  <= DATA_W'(data_i);
      end
   end

   wb_stage_register_file #(
      .BITSIZE (BITSIZE),
      .NREGS   (NREGS)
   ) u_rf (
      .clk    (clk),
      .rst_i  (rst_i),
      .we     (commit),
      .waddr  (rd),
      .wdata  (held),
      .raddr1 (rs1_addr_i),
      .rdata1 (raw1),
      .raddr2 (rs2_addr_i),
      .rdata2 (raw2)
   );

   assign rs1_data_o =
      (rst_i || rs1_addr_i == 5'd0)  ? '0   :
      (we && rs1_addr_i == rd)       ? held : raw1;

   assign rs2_data_o =
      (rst_i || rs2_addr_i == 5'd0)  ? '0   :
      (we && rs2_addr_i == rd)       ? held : raw2;

`ifdef WB_INSTRET_EN
   logic [63:0] instret_q;

   // Count every valid entry that leaves the stage.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         instret_q <= '0;
      end else if (!halt_i && entry_q.valid) begin
         instret_q <= instret_q + 64'd1;
      end
   end

   assign instret_o = instret_q;
`else
   assign instret_o = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus random traffic.
// A behavioural model is compared against the DUT every cycle.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        halt_i;
   logic        valid_i;
   logic        ack_o;
   logic [31:0] instr_i;
   logic [31:0] data_i;
   logic [4:0]  rs1_addr_i;
   logic [31:0] rs1_data_o;
   logic [4:0]  rs2_addr_i;
   logic [31:0] rs2_data_o;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic [63:0] instret_o;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk        (clk),
      .rst_i      (rst_i),
      .halt_i     (halt_i),
      .valid_i    (valid_i),
      .ack_o      (ack_o),
      .instr_i    (instr_i),
      .data_i     (data_i),
      .rs1_addr_i (rs1_addr_i),
      .rs1_data_o (rs1_data_o),
      .rs2_addr_i (rs2_addr_i),
      .rs2_data_o (rs2_data_o),
      .wb_valid_o (wb_valid_o),
      .wb_rd_o    (wb_rd_o),
      .instret_o  (instret_o)
   );

   localparam logic [6:0] LOAD   = 7'h03;
   localparam logic [6:0] STORE  = 7'h23;
   localparam logic [6:0] OPIMM  = 7'h13;
   localparam logic [6:0] OP     = 7'h33;
   localparam logic [6:0] LUI    = 7'h37;
   localparam logic [6:0] AUIPC  = 7'h17;
   localparam logic [6:0] JAL    = 7'h6f;
   localparam logic [6:0] JALR   = 7'h67;
   localparam logic [6:0] BRANCH = 7'h63;
   localparam logic [6:0] FENCE  = 7'h0f;
   localparam logic [6:0] SYSTEM = 7'h73;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Behavioural model: architectural registers, the held entry, a count.
   logic [31:0] m_regs [32];
   logic        m_valid = 1'b0;
   logic [31:0] m_instr = '0;
   logic [31:0] m_data = '0;
   logic [63:0] m_cnt = '0;

   function automatic logic m_writes();
      logic [6:0] op;
      op = m_instr[6:0];
      return m_valid && m_instr[11:7] != 5'd0 &&
             (op inside {LOAD, OPIMM, OP, LUI, AUIPC, JAL, JALR});
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (rst_i || a == 5'd0) return 32'd0;
      if (m_writes() && a == m_instr[11:7]) return m_data;
      return m_regs[a];
   endfunction

   function automatic logic [63:0] cnt_exp(input logic [63:0] n);
`ifdef WB_INSTRET_EN
      return n;
`else
      return 64'd0 & n;
`endif
   endfunction

   function automatic logic [31:0] mk(input logic [6:0] op,
                                      input logic [4:0] rd);
      return {20'h0, rd, op};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   // Model state advances on each rising edge from the applied inputs.
   always @(posedge clk) begin
      if (rst_i) begin
         for (int i = 0; i < 32; i++) m_regs[i] = '0;
         m_valid = 1'b0;
         m_instr = '0;
         m_data  = '0;
         m_cnt   = '0;
      end else if (!halt_i) begin
         if (m_writes()) m_regs[m_instr[11:7]] = m_data;
         if (m_valid) m_cnt = m_cnt + 64'd1;
         m_valid = valid_i;
         m_instr = instr_i;
         m_data  = data_i;
      end
   end

   // Compare every DUT output against the model mid-cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         logic ev;
         ev = !rst_i && m_writes();
         chk("ack", 64'(ack_o), 64'(valid_i & !halt_i & !rst_i));
         chk("wb_valid", 64'(wb_valid_o), 64'(ev));
         chk("wb_rd", 64'(wb_rd_o), 64'(ev ? m_instr[11:7] : 5'd0));
         chk("rs1", 64'(rs1_data_o), 64'(m_read(rs1_addr_i)));
         chk("rs2", 64'(rs2_data_o), 64'(m_read(rs2_addr_i)));
         chk("instret", instret_o, cnt_exp(m_cnt));
      end
   end

   task automatic cyc(input logic r, input logic h, input logic v,
                      input logic [31:0] ins, input logic [31:0] d,
                      input logic [4:0] a1, input logic [4:0] a2);
      @(posedge clk);
      #2;
      rst_i      = r;
      halt_i     = h;
      valid_i    = v;
      instr_i    = ins;
      data_i     = d;
      rs1_addr_i = a1;
      rs2_addr_i = a2;
      @(negedge clk);
      #1;
   endtask

   logic [6:0] ops [12];

   initial begin
      logic [31:0] u;
      logic [6:0]  op;
      logic        r, h, v;
      rst_i = 1'b1; halt_i = 1'b0; valid_i = 1'b1;
      instr_i = mk(OP, 5'd2); data_i = 32'h11;
      rs1_addr_i = 5'd5; rs2_addr_i = 5'd31;
      ops = '{LOAD, STORE, OPIMM, OP, LUI, AUIPC,
              JAL, JALR, BRANCH, FENCE, SYSTEM, 7'h00};

      // Reset held two cycles with valid_i asserted.
      cyc(1, 0, 1, mk(OP, 5'd2), 32'h11, 5'd5, 5'd31);
      chk_en = 1'b1;
      chk("rst_ack", 64'(ack_o), 64'd0);
      chk("rst_rs1", 64'(rs1_data_o), 64'd0);
      chk("rst_rs2", 64'(rs2_data_o), 64'd0);
      cyc(1, 0, 1, mk(OP, 5'd2), 32'h11, 5'd17, 5'd2);
      chk("rst_rs1b", 64'(rs1_data_o), 64'd0);
      chk("rst_instret", instret_o, 64'd0);
      chk("rst_wbv", 64'(wb_valid_o), 64'd0);

      // ALU writeback with bypass, then array read.
      cyc(0, 0, 1, mk(OPIMM, 5'd5), 32'hDEADBEEF, 5'd5, 5'd0);
      chk("alu_ack", 64'(ack_o), 64'd1);
      chk("alu_pre", 64'(rs1_data_o), 64'd0);
      cyc(0, 0, 0, 32'd0, 32'd0, 5'd5, 5'd0);
      chk("alu_wbv", 64'(wb_valid_o), 64'd1);
      chk("alu_rd", 64'(wb_rd_o), 64'd5);
      chk("alu_byp", 64'(rs1_data_o), 64'hDEADBEEF);
      cyc(0, 0, 0, 32'd0, 32'd0, 5'd5, 5'd0);
      chk("alu_wbv0", 64'(wb_valid_o), 64'd0);
      chk("alu_arr", 64'(rs1_data_o), 64'hDEADBEEF);

      // x0 destination and a store never write.
      cyc(0, 0, 1, mk(LUI, 5'd0), 32'h1234, 5'd0, 5'd0);
      cyc(0, 0, 1, mk(STORE, 5'd9), 32'd0, 5'd0, 5'd9);
      chk("lui0_wbv", 64'(wb_valid_o), 64'd0);
      chk("x0_read", 64'(rs1_data_o), 64'd0);
      cyc(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd9);
      chk("st_wbv", 64'(wb_valid_o), 64'd0);
      chk("st_x9", 64'(rs2_data_o), 64'd0);
      cyc(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd0);
      chk("cnt3", instret_o, cnt_exp(64'd3));

      // Back-to-back writes to the same rd.
      cyc(0, 0, 1, mk(JAL, 5'd1), 32'h104, 5'd0, 5'd1);
      cyc(0, 0, 1, mk(LOAD, 5'd1), 32'h55, 5'd0, 5'd1);
      chk("b2b_jal", 64'(rs2_data_o), 64'h104);
      cyc(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd1);
      chk("b2b_ld", 64'(rs2_data_o), 64'h55);
      chk("b2b_wbv", 64'(wb_valid_o), 64'd1);
      cyc(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd1);
      chk("b2b_arr", 64'(rs2_data_o), 64'h55);
      chk("b2b_wbv0", 64'(wb_valid_o), 64'd0);

      // Halt three cycles with an entry held.
      cyc(0, 0, 1, mk(OP, 5'd3), 32'd7, 5'd3, 5'd0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 1, mk(OP, 5'd3), 32'd9, 5'd3, 5'd0);
         chk("halt_ack", 64'(ack_o), 64'd0);
         chk("halt_wbv", 64'(wb_valid_o), 64'd1);
         chk("halt_rd", 64'(wb_rd_o), 64'd3);
         chk("halt_rs1", 64'(rs1_data_o), 64'd7);
         chk("halt_cnt", instret_o, cnt_exp(64'd5));
      end
      cyc(0, 0, 0, 32'd0, 32'd0, 5'd3, 5'd0);
      chk("rel_wbv", 64'(wb_valid_o), 64'd1);
      chk("rel_rs1", 64'(rs1_data_o), 64'd7);
      cyc(0, 0, 0, 32'd0, 32'd0, 5'd3, 5'd0);
      chk("rel_wbv0", 64'(wb_valid_o), 64'd0);
      chk("rel_arr", 64'(rs1_data_o), 64'd7);
      chk("rel_cnt", instret_o, cnt_exp(64'd6));

      // Reset while an entry is held.
      cyc(0, 0, 1, mk(OP, 5'd4), 32'hAA, 5'd4, 5'd0);
      cyc(1, 0, 0, 32'd0, 32'd0, 5'd4, 5'd3);
      chk("mrst_ack", 64'(ack_o), 64'd0);
      chk("mrst_wbv", 64'(wb_valid_o), 64'd0);
      chk("mrst_rd", 64'(wb_rd_o), 64'd0);
      chk("mrst_rs1", 64'(rs1_data_o), 64'd0);
      cyc(0, 0, 0, 32'd0, 32'd0, 5'd4, 5'd3);
      chk("mrst_x4", 64'(rs1_data_o), 64'd0);
      chk("mrst_x3", 64'(rs2_data_o), 64'd0);
      chk("mrst_cnt", instret_o, 64'd0);

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         u  = $urandom();
         op = ops[$urandom_range(0, 11)];
         if (op == 7'h00) op = u[6:0];
         r = ($urandom_range(0, 63) == 0);
         h = ($urandom_range(0, 7) == 0);
         v = ($urandom_range(0, 3) != 0);
         cyc(r, h, v, {u[31:12], 5'($urandom_range(0, 7)), op},
             $urandom(), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)));
      end
      cyc(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd0);
      chk_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
